// File: rtl/check_vital_trend.sv
// Multi-channel dual moving-average trend detector sharing one FSM and per-window ring RAMs.
// Optional release hysteresis is compiled in with `define CHECK_TREND_HYST_EN.
module check_vital_trend #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
  parameter int AVG_W     = 6,
  parameter int SHORT_LEN = 16,
  parameter int LONG_LEN  = 120,
  parameter int RATIO_NUM = 23,
  parameter int RATIO_DEN = 20,
  parameter int HYST_NUM  = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick_1hz,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic [NUM_CH-1:0]        trend_flag,
  output logic [NUM_CH*AVG_W-1:0]  short_avg,
  output logic [NUM_CH*AVG_W-1:0]  long_avg,
  output logic [NUM_CH-1:0]        avg_sat,
  output logic [2:0]               state_dbg
);

  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_S_W  = DATA_W + $clog2(SHORT_LEN);
  localparam int SUM_L_W  = DATA_W + $clog2(LONG_LEN);
  localparam int PS_W     = $clog2(SHORT_LEN);
  localparam int PL_W     = $clog2(LONG_LEN);
  localparam int FS_W     = $clog2(SHORT_LEN + 1);
  localparam int FL_W     = $clog2(LONG_LEN + 1);
  localparam int AS_W     = $clog2(NUM_CH * SHORT_LEN);
  localparam int AL_W     = $clog2(NUM_CH * LONG_LEN);
  localparam int LHS_K    = LONG_LEN * RATIO_DEN;
  localparam int RHS_K    = SHORT_LEN * RATIO_NUM;
  localparam int RHS_KMAX = SHORT_LEN * ((HYST_NUM > RATIO_NUM) ? HYST_NUM : RATIO_NUM);
  localparam int LHS_W    = SUM_S_W + $clog2(LHS_K + 1);
  localparam int RHS_W    = SUM_L_W + $clog2(RHS_KMAX + 1);
  localparam int CMP_W    = (LHS_W > RHS_W) ? LHS_W : RHS_W;
  localparam bit S_POW2   = (SHORT_LEN & (SHORT_LEN - 1)) == 0;
  localparam bit L_POW2   = (LONG_LEN & (LONG_LEN - 1)) == 0;
  localparam logic [AVG_W-1:0] AVG_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_UPD, S_CMP, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [CH_W-1:0]          ch;
  logic [NUM_CH*DATA_W-1:0] samp_q;
  logic [DATA_W-1:0]        samp_ch [NUM_CH];
  logic [PS_W-1:0]          ptr_s;
  logic [PL_W-1:0]          ptr_l;
  logic [FS_W-1:0]          fill_s;
  logic [FL_W-1:0]          fill_l;
  logic [SUM_S_W-1:0]       sum_s [NUM_CH];
  logic [SUM_L_W-1:0]       sum_l [NUM_CH];
  logic [AVG_W-1:0]         short_q [NUM_CH];
  logic [AVG_W-1:0]         long_q [NUM_CH];
  logic [DATA_W-1:0]        mem_s [NUM_CH*SHORT_LEN];
  logic [DATA_W-1:0]        mem_l [NUM_CH*LONG_LEN];
  logic [DATA_W-1:0]        tail_s_raw, tail_l_raw;

  logic [AS_W-1:0]    addr_s;
  logic [AL_W-1:0]    addr_l;
  logic [DATA_W-1:0]  cur_sample, tail_s, tail_l;
  logic [SUM_S_W-1:0] sum_s_nxt, s_div;
  logic [SUM_L_W-1:0] sum_l_nxt, l_div;
  logic [CMP_W-1:0]   lhs, rhs;
  logic               full_ok, flag_nxt, sat_nxt;
  logic [AVG_W-1:0]   short_nxt, long_nxt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign samp_ch[c]                   = samp_q[c*DATA_W +: DATA_W];
    assign short_avg[c*AVG_W +: AVG_W]  = short_q[c];
    assign long_avg[c*AVG_W +: AVG_W]   = long_q[c];
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick_1hz) state_nxt = S_RD;
      S_RD:    state_nxt = S_UPD;
      S_UPD:   state_nxt = S_CMP;
      S_CMP:   state_nxt = (ch == CH_W'(NUM_CH - 1)) ? S_DONE : S_RD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tail values are real samples only once the window has wrapped at least once.
  always_comb begin
    addr_s     = AS_W'(ch) * AS_W'(SHORT_LEN) + AS_W'(ptr_s);
    addr_l     = AL_W'(ch) * AL_W'(LONG_LEN) + AL_W'(ptr_l);
    cur_sample = samp_ch[ch];
    tail_s     = (fill_s == FS_W'(SHORT_LEN)) ? tail_s_raw : '0;
    tail_l     = (fill_l == FL_W'(LONG_LEN)) ? tail_l_raw : '0;
    sum_s_nxt  = sum_s[ch] - SUM_S_W'(tail_s) + SUM_S_W'(cur_sample);
    sum_l_nxt  = sum_l[ch] - SUM_L_W'(tail_l) + SUM_L_W'(cur_sample);
  end

  // Fill counters count samples before this pass, so LEN-1 means the window is full after it.
  always_comb begin
    lhs     = CMP_W'(sum_s[ch]) * CMP_W'(LHS_K);
    rhs     = CMP_W'(sum_l[ch]) * CMP_W'(RHS_K);
    full_ok = (fill_s >= FS_W'(SHORT_LEN - 1)) && (fill_l >= FL_W'(LONG_LEN - 1));
`ifdef CHECK_TREND_HYST_EN
    if (trend_flag[ch])
      flag_nxt = full_ok && (lhs >= CMP_W'(sum_l[ch]) * CMP_W'(SHORT_LEN * HYST_NUM));
    else
      flag_nxt = full_ok && (lhs >= rhs);
`else
    flag_nxt = full_ok && (lhs >= rhs);
`endif
    s_div     = S_POW2 ? (sum_s[ch] >> $clog2(SHORT_LEN)) : (sum_s[ch] / SUM_S_W'(SHORT_LEN));
    l_div     = L_POW2 ? (sum_l[ch] >> $clog2(LONG_LEN)) : (sum_l[ch] / SUM_L_W'(LONG_LEN));
    short_nxt = (s_div > SUM_S_W'(AVG_MAX)) ? AVG_MAX : s_div[AVG_W-1:0];
    long_nxt  = (l_div > SUM_L_W'(AVG_MAX)) ? AVG_MAX : l_div[AVG_W-1:0];
    sat_nxt   = (s_div > SUM_S_W'(AVG_MAX)) || (l_div > SUM_L_W'(AVG_MAX));
  end

  // Ring RAM has no reset; stale contents are masked by the fill counters.
  always_ff @(posedge clk) begin
    if (state == S_RD) begin
      tail_s_raw <= mem_s[addr_s];
      tail_l_raw <= mem_l[addr_l];
    end
    if (state == S_UPD) begin
      mem_s[addr_s] <= cur_sample;
      mem_l[addr_l] <= cur_sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch         <= '0;
      samp_q     <= '0;
      ptr_s      <= '0;
      ptr_l      <= '0;
      fill_s     <= '0;
      fill_l     <= '0;
      overrun    <= 1'b0;
      trend_flag <= '0;
      avg_sat    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_s[c]   <= '0;
        sum_l[c]   <= '0;
        short_q[c] <= '0;
        long_q[c]  <= '0;
      end
    end else begin
      overrun <= tick_1hz && (state != S_IDLE);
      case (state)
        S_IDLE: if (tick_1hz) begin
          samp_q <= sample_in;
          ch     <= '0;
        end
        S_UPD: begin
          sum_s[ch] <= sum_s_nxt;
          sum_l[ch] <= sum_l_nxt;
        end
        S_CMP: begin
          trend_flag[ch] <= flag_nxt;
          avg_sat[ch]    <= sat_nxt;
          short_q[ch]    <= short_nxt;
          long_q[ch]     <= long_nxt;
          if (ch != CH_W'(NUM_CH - 1)) ch <= ch + 1'b1;
        end
        S_DONE: begin
          ptr_s <= (ptr_s == PS_W'(SHORT_LEN - 1)) ? '0 : ptr_s + 1'b1;
          ptr_l <= (ptr_l == PL_W'(LONG_LEN - 1)) ? '0 : ptr_l + 1'b1;
          if (fill_s != FS_W'(SHORT_LEN)) fill_s <= fill_s + 1'b1;
          if (fill_l != FL_W'(LONG_LEN)) fill_l <= fill_l + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_check_vital_trend.sv
// Randomised bench for check_vital_trend: a window-history model feeds an expected queue that a
// per-cycle compare process drains at each done; literal checks pin the model on the named scenarios.
module tb_check_vital_trend;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 8;
  localparam int AVG_W     = 6;
  localparam int SHORT_LEN = 16;
  localparam int LONG_LEN  = 120;
  localparam int RATIO_NUM = 23;
  localparam int RATIO_DEN = 20;
  localparam int HYST_NUM  = 21;
  localparam int LAT       = 3 * NUM_CH + 1;
  localparam int VW        = NUM_CH * (2 + 2 * AVG_W);
  localparam int AMAX      = (1 << AVG_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     tick_1hz = 1'b0;
  logic [NUM_CH*DATA_W-1:0] sample_in = '0;
  logic                     busy, done, overrun;
  logic [NUM_CH-1:0]        trend_flag, avg_sat;
  logic [NUM_CH*AVG_W-1:0]  short_avg, long_avg;
  logic [2:0]               state_dbg;

  int total = 0;
  int bad   = 0;
  int ovr_cnt = 0;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] cur_exp;
  bit            have_exp = 0;

  int hist [NUM_CH][$];
  int nseen [NUM_CH];
  bit m_flag [NUM_CH];

  check_vital_trend #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_W(AVG_W), .SHORT_LEN(SHORT_LEN),
    .LONG_LEN(LONG_LEN), .RATIO_NUM(RATIO_NUM), .RATIO_DEN(RATIO_DEN), .HYST_NUM(HYST_NUM)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .sample_in(sample_in),
    .busy(busy), .done(done), .overrun(overrun), .trend_flag(trend_flag),
    .short_avg(short_avg), .long_avg(long_avg), .avg_sat(avg_sat), .state_dbg(state_dbg)
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---- model ----
  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      hist[c].delete();
      nseen[c]  = 0;
      m_flag[c] = 0;
    end
  endtask

  function automatic logic [VW-1:0] model_push(input logic [NUM_CH*DATA_W-1:0] smp);
    logic [NUM_CH-1:0]       vf, vs;
    logic [NUM_CH*AVG_W-1:0] vsh, vlo;
    for (int c = 0; c < NUM_CH; c++) begin
      longint s, l, sa, la, lhs, rhs;
      int n;
      bit ok;
      hist[c].push_back(int'(smp[c*DATA_W +: DATA_W]));
      if (hist[c].size() > LONG_LEN) void'(hist[c].pop_front());
      nseen[c]++;
      n = hist[c].size();
      s = 0;
      l = 0;
      for (int i = 0; i < n; i++) begin
        l += hist[c][i];
        if (i >= n - SHORT_LEN) s += hist[c][i];
      end
      lhs = s * LONG_LEN * RATIO_DEN;
      rhs = l * SHORT_LEN * RATIO_NUM;
      ok  = (nseen[c] >= LONG_LEN) && (nseen[c] >= SHORT_LEN);
`ifdef CHECK_TREND_HYST_EN
      if (m_flag[c]) m_flag[c] = ok && !(lhs < l * SHORT_LEN * HYST_NUM);
      else           m_flag[c] = ok && (lhs >= rhs);
`else
      m_flag[c] = ok && (lhs >= rhs);
`endif
      sa = s / SHORT_LEN;
      la = l / LONG_LEN;
      vf[c] = m_flag[c];
      vs[c] = (sa > AMAX) || (la > AMAX);
      vsh[c*AVG_W +: AVG_W] = AVG_W'((sa > AMAX) ? AMAX : sa);
      vlo[c*AVG_W +: AVG_W] = AVG_W'((la > AMAX) ? AMAX : la);
    end
    return {vf, vs, vsh, vlo};
  endfunction

  // ---- scoreboard: outputs must match the latest completed pass on every idle cycle ----
  always @(negedge clk) begin
    if (rst) begin
      have_exp = 0;
    end else if (done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: actual=done required=no pass pending");
      end else begin
        cur_exp  = exp_q.pop_front();
        have_exp = 1;
      end
    end else if (!busy && have_exp) begin
      total++;
      if ({trend_flag, avg_sat, short_avg, long_avg} !== cur_exp) begin
        bad++;
        $display("FAIL outputs: actual=%h required=%h", {trend_flag, avg_sat, short_avg, long_avg}, cur_exp);
      end
    end
  end

  always @(negedge clk) if (!rst && overrun) ovr_cnt++;

  // ---- driver tasks ----
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_1hz = 1'b0;
    exp_q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, overrun, trend_flag, avg_sat, short_avg, long_avg}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // extra_at > 0 raises a second tick that many cycles after the accepted one.
  task automatic do_tick(input logic [NUM_CH*DATA_W-1:0] smp, input int extra_at);
    int ovr0, lat;
    bit got;
    ovr0 = ovr_cnt;
    got  = 0;
    lat  = 0;
    @(negedge clk);
    tick_1hz  = 1'b1;
    sample_in = smp;
    exp_q.push_back(model_push(smp));
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      tick_1hz = (k == extra_at);
      if (k == extra_at) sample_in = ~smp;
      if (done) begin
        got = 1;
        lat = k;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done_timeout: actual=no done in 40 cycles required=done at %0d", LAT);
    end else if (lat != LAT) begin
      bad++;
      $display("FAIL latency: actual=%0d required=%0d", lat, LAT);
    end
    @(negedge clk);
    tick_1hz = 1'b0;
    chk("done_one_cycle", 64'(done), 64'd0);
    @(negedge clk);
    chk("overrun_count", 64'(ovr_cnt - ovr0), 64'((extra_at >= 1 && extra_at <= LAT) ? 1 : 0));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] all_ch(input int v);
    logic [NUM_CH*DATA_W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = DATA_W'(v);
    return r;
  endfunction

  // ---- stimulus ----
  initial begin
    int base [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] smp;

    do_reset();

    // constant 10 fills both windows
    for (int t = 0; t < LONG_LEN; t++) do_tick(all_ch(10), 0);
    chk("t1_flag", 64'(trend_flag), 64'd0);
    chk("t1_short", 64'(short_avg), 64'({NUM_CH{6'd10}}));
    chk("t1_long", 64'(long_avg), 64'({NUM_CH{6'd10}}));

    // step to 20: flag rises on the third tick
    do_tick(all_ch(20), 0);
    chk("t2_flag1", 64'(trend_flag), 64'd0);
    do_tick(all_ch(20), 0);
    chk("t2_flag2", 64'(trend_flag), 64'd0);
    do_tick(all_ch(20), 0);
    chk("t2_flag3", 64'(trend_flag), 64'hF);
    chk("t2_short0", 64'(short_avg[5:0]), 64'd11);
    chk("t2_long0", 64'(long_avg[5:0]), 64'd10);

    // back down to 10: flag release observed by the model
    for (int t = 0; t < 20; t++) do_tick(all_ch(10), 0);

    // random plateaus with jitter
    for (int t = 0; t < 180; t++) begin
      if (t % 40 == 0)
        for (int c = 0; c < NUM_CH; c++) base[c] = $urandom_range(0, 220);
      for (int c = 0; c < NUM_CH; c++)
        smp[c*DATA_W +: DATA_W] = DATA_W'(base[c] + $urandom_range(0, 30));
      do_tick(smp, 0);
    end

    // saturation on ch0 only
    smp = all_ch(10);
    smp[DATA_W-1:0] = 8'd200;
    for (int t = 0; t < 60; t++) do_tick(smp, 0);
    chk("t3_short0", 64'(short_avg[5:0]), 64'd63);
    chk("t3_long0", 64'(long_avg[5:0]), 64'd63);
    chk("t3_sat0", 64'(avg_sat[0]), 64'd1);
    chk("t3_short1", 64'(short_avg[11:6]), 64'd10);

    // dropped ticks while busy, including the DONE cycle
    do_tick(all_ch(30), 5);
    do_tick(all_ch(31), LAT);
    do_tick(all_ch(32), 1);
    do_tick(all_ch(33), LAT - 1);

    // reset in the middle of a pass
    @(negedge clk);
    tick_1hz  = 1'b1;
    sample_in = all_ch(90);
    @(negedge clk);
    tick_1hz = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_async_clear", 64'({busy, done, overrun, trend_flag, avg_sat, short_avg, long_avg}), 64'd0);
    do_reset();
    for (int t = 0; t < LONG_LEN; t++) do_tick(all_ch(10), 0);
    chk("t5_flag", 64'(trend_flag), 64'd0);
    chk("t5_short", 64'(short_avg), 64'({NUM_CH{6'd10}}));
    chk("t5_long", 64'(long_avg), 64'({NUM_CH{6'd10}}));
    chk("t5_sat", 64'(avg_sat), 64'd0);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
